// File: rtl/clk_div_multi.sv
// Purpose: NUM_CH independent programmable dividers with square/pulse outputs and shadowed config.
// Latency: o_clk/o_tick are registered, one cycle behind the counter state they decode.
// Backpressure: none; config writes are always accepted into the shadow and applied at wrap or sync.
module clk_div_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 28,
   parameter int DEFAULT_DIV = 100000,
   parameter int CH_IDX_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sync,
   input  logic                cfg_we,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [CNT_W-1:0]    cfg_div,
   input  logic                cfg_mode,
   output logic [NUM_CH-1:0]   o_clk,
   output logic [NUM_CH-1:0]   o_tick,
   output logic [NUM_CH-1:0]   cfg_pending
);

   // A divisor below 2 cannot produce a period, so it is stored as 2.
   logic [CNT_W-1:0] div_in;
   assign div_in = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] sh_div;
      logic             mode;
      logic             sh_mode;
      logic             pend;
      logic             clk_q;
      logic             tick_q;
      logic             wr_hit;
      logic             at_end;
      logic             mode_after_sync;

      // Out-of-range channel indices match no channel, so such writes are dropped.
      assign wr_hit          = cfg_we && (cfg_ch == CH_IDX_W'(i));
      assign at_end          = (cnt == div - CNT_W'(1));
      assign mode_after_sync = pend ? sh_mode : mode;

      // Counter, active/shadow configuration and registered outputs for one channel.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt     <= '0;
            div     <= CNT_W'(DEFAULT_DIV);
            mode    <= 1'b0;
            sh_div  <= CNT_W'(DEFAULT_DIV);
            sh_mode <= 1'b0;
            pend    <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else begin
            if (sync) begin
               // Re-phase: restart the period and commit any shadow at once.
               cnt    <= '0;
               tick_q <= 1'b0;
               if (pend) begin
                  div  <= sh_div;
                  mode <= sh_mode;
               end
               pend <= 1'b0;
               // Pulse output mirrors the suppressed tick; square output is
               // refreshed from cnt = 0 on the next counting edge.
               if (mode_after_sync) begin
                  clk_q <= 1'b0;
               end
            end else if (en) begin
               tick_q <= at_end;
               clk_q  <= mode ? at_end : (cnt < (div >> 1));
               if (at_end) begin
                  cnt <= '0;
                  // Shadow commits only on a period boundary, so no short/long period.
                  if (pend) begin
                     div  <= sh_div;
                     mode <= sh_mode;
                     pend <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end else begin
               tick_q <= 1'b0;
            end

            // A write lands last so it stays pending even on a wrap/sync edge.
            if (wr_hit) begin
               sh_div  <= div_in;
               sh_mode <= cfg_mode;
               pend    <= 1'b1;
            end
         end
      end

      assign o_clk[i]       = clk_q;
      assign o_tick[i]      = tick_q;
      assign cfg_pending[i] = pend;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed stimulus with a time-indexed expectation queue.
// Expectations are keyed by posedge count and checked at the following negedge.
// Small config (DEFAULT_DIV = 10) keeps the hand-computed timelines short.
module tb_clk_div_multi;

   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 10;
   localparam int CH_IDX_W    = 3;

   logic                clk      = 1'b0;
   logic                rst      = 1'b1;
   logic                en       = 1'b1;
   logic                sync     = 1'b0;
   logic                cfg_we   = 1'b0;
   logic [CH_IDX_W-1:0] cfg_ch   = '0;
   logic [CNT_W-1:0]    cfg_div  = '0;
   logic                cfg_mode = 1'b0;
   logic [NUM_CH-1:0]   o_clk;
   logic [NUM_CH-1:0]   o_tick;
   logic [NUM_CH-1:0]   cfg_pending;

   clk_div_multi #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .CH_IDX_W    (CH_IDX_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sync        (sync),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_div     (cfg_div),
      .cfg_mode    (cfg_mode),
      .o_clk       (o_clk),
      .o_tick      (o_tick),
      .cfg_pending (cfg_pending)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   // sel: 0 = o_clk, 1 = o_tick, 2 = cfg_pending
   typedef struct {
      int    at;
      int    sel;
      int    ch;
      logic  v;
      string name;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic push_exp(int at, int sel, int ch, logic v, string name);
      exp_t e;
      e.at = at; e.sel = sel; e.ch = ch; e.v = v; e.name = name;
      sbq.push_back(e);
   endtask

   // One square-mode period starting at edge 'start': high floor(d/2), tick on the last.
   task automatic exp_sq(int ch, int start, int d, string nm);
      for (int j = 0; j < d; j++) begin
         push_exp(start + j, 0, ch, logic'(j < d / 2), {nm, "_clk"});
         push_exp(start + j, 1, ch, logic'(j == d - 1), {nm, "_tick"});
      end
   endtask

   // One pulse-mode period: o_clk and o_tick both high only on the last cycle.
   task automatic exp_pulse(int ch, int start, int d, string nm);
      for (int j = 0; j < d; j++) begin
         push_exp(start + j, 0, ch, logic'(j == d - 1), {nm, "_clk"});
         push_exp(start + j, 1, ch, logic'(j == d - 1), {nm, "_tick"});
      end
   endtask

   // Monitor: compare every expectation that falls due at this edge.
   logic       mon_act;
   logic [1:0] mon_ch;
   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].at <= edges) begin
            mon_ch = 2'(sbq[i].ch);
            case (sbq[i].sel)
               0:       mon_act = o_clk[mon_ch];
               1:       mon_act = o_tick[mon_ch];
               default: mon_act = cfg_pending[mon_ch];
            endcase
            n_tests++;
            if (sbq[i].at != edges || mon_act !== sbq[i].v) begin
               n_fail++;
               $display("FAIL %s ch%0d @edge %0d (due %0d): got %b, expected %b",
                        sbq[i].name, sbq[i].ch, edges, sbq[i].at, mon_act, sbq[i].v);
            end
            sbq.delete(i);
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto_edge(int e);
      while (edges < e) step(1);
   endtask

   // Drives a write now; it is sampled at the next edge.
   task automatic write_cfg(int ch, int d, logic m);
      cfg_we   = 1'b1;
      cfg_ch   = CH_IDX_W'(ch);
      cfg_div  = CNT_W'(d);
      cfg_mode = m;
      step(1);
      cfg_we   = 1'b0;
   endtask

   // Two reset edges; base = last reset edge, so cnt = 0 before edge base+1.
   task automatic do_reset(output int base);
      rst = 1'b1;
      step(1);
      for (int c = 0; c < NUM_CH; c++) begin
         push_exp(edges + 1, 0, c, 1'b0, "rst_clk");
         push_exp(edges + 1, 1, c, 1'b0, "rst_tick");
         push_exp(edges + 1, 2, c, 1'b0, "rst_pend");
      end
      step(1);
      rst  = 1'b0;
      base = edges;
   endtask

   int b;
   int b2;

   initial begin
      // Reset / default period
      do_reset(b);
      exp_sq(0, b + 1,  10, "t1_ch0");
      exp_sq(0, b + 11, 10, "t1_ch0_p2");
      exp_sq(3, b + 1,  10, "t1_ch3");
      goto_edge(b + 20);

      // Odd divisor, then clamp of 0 to 2
      do_reset(b);
      exp_sq(1, b + 1, 10, "t2_old");
      push_exp(b + 1,  2, 1, 1'b1, "t2_pend_set");
      push_exp(b + 10, 2, 1, 1'b0, "t2_pend_clr");
      exp_sq(1, b + 11, 7, "t2_div7");
      push_exp(b + 13, 2, 1, 1'b1, "t2_pend2_set");
      push_exp(b + 17, 2, 1, 1'b0, "t2_pend2_clr");
      exp_sq(1, b + 18, 2, "t2_clamp");
      exp_sq(1, b + 20, 2, "t2_clamp_p2");
      write_cfg(1, 7, 1'b0);
      goto_edge(b + 12);
      write_cfg(1, 0, 1'b0);
      goto_edge(b + 21);

      // Glitch-free mid-period update
      do_reset(b);
      push_exp(b + 3,  2, 0, 1'b0, "t3_pend_pre");
      push_exp(b + 4,  2, 0, 1'b1, "t3_pend_set");
      push_exp(b + 9,  2, 0, 1'b1, "t3_pend_hold");
      push_exp(b + 10, 2, 0, 1'b0, "t3_pend_clr");
      exp_sq(0, b + 1,  10, "t3_old");
      exp_sq(0, b + 11, 4,  "t3_new");
      exp_sq(0, b + 15, 4,  "t3_new_p2");
      goto_edge(b + 3);
      write_cfg(0, 4, 1'b0);
      goto_edge(b + 18);

      // Pulse mode and out-of-range channel write
      do_reset(b);
      push_exp(b + 1,  2, 2, 1'b1, "t4_pend_set");
      push_exp(b + 10, 2, 2, 1'b0, "t4_pend_clr");
      push_exp(b + 10, 1, 2, 1'b1, "t4_old_tick");
      exp_pulse(2, b + 11, 3, "t4_pulse");
      exp_pulse(2, b + 14, 3, "t4_pulse_p2");
      push_exp(b + 5, 2, 0, 1'b0, "t4_bad_pend0");
      push_exp(b + 5, 2, 1, 1'b0, "t4_bad_pend1");
      push_exp(b + 5, 2, 3, 1'b0, "t4_bad_pend3");
      exp_sq(1, b + 1,  10, "t4_ch1");
      exp_sq(1, b + 11, 10, "t4_ch1_p2");
      write_cfg(2, 3, 1'b1);
      goto_edge(b + 3);
      write_cfg(5, 2, 1'b1);
      goto_edge(b + 20);

      // Enable freeze across a would-be tick, with a write while frozen
      do_reset(b);
      for (int e = b + 1; e <= b + 16; e++) begin
         push_exp(e, 0, 0, logic'(e <= b + 11), "t5_clk");
         push_exp(e, 1, 0, logic'(e == b + 16), "t5_tick");
      end
      exp_sq(0, b + 17, 10, "t5_after");
      push_exp(b + 7,  2, 3, 1'b1, "t5_pend_set");
      push_exp(b + 10, 2, 3, 1'b1, "t5_pend_frozen");
      push_exp(b + 15, 2, 3, 1'b1, "t5_pend_hold");
      push_exp(b + 16, 2, 3, 1'b0, "t5_pend_clr");
      exp_sq(3, b + 17, 4, "t5_ch3");
      exp_sq(3, b + 21, 4, "t5_ch3_p2");
      goto_edge(b + 4);
      en = 1'b0;
      goto_edge(b + 6);
      write_cfg(3, 4, 1'b0);
      goto_edge(b + 10);
      en = 1'b1;
      goto_edge(b + 26);

      // Sync with channels at different phases, plus a write on the sync cycle
      do_reset(b);
      push_exp(b + 1,  2, 1, 1'b1, "t6_pend1_set");
      push_exp(b + 10, 2, 1, 1'b0, "t6_pend1_clr");
      push_exp(b + 10, 2, 2, 1'b0, "t6_pend2_clr");
      exp_sq(1, b + 11, 3, "t6_ch1_pre");
      push_exp(b + 12, 2, 3, 1'b1, "t6_pend3_set");
      push_exp(b + 15, 2, 3, 1'b1, "t6_pend3_hold");
      push_exp(b + 16, 2, 3, 1'b0, "t6_pend3_sync");
      for (int c = 0; c < NUM_CH; c++) push_exp(b + 16, 1, c, 1'b0, "t6_sync_tick");
      push_exp(b + 16, 2, 1, 1'b1, "t6_pend1_sync_wr");
      push_exp(b + 19, 2, 1, 1'b0, "t6_pend1_wrap");
      exp_sq(0, b + 17, 10, "t6_ch0");
      exp_sq(1, b + 17, 3,  "t6_ch1");
      exp_sq(1, b + 20, 6,  "t6_ch1_new");
      exp_sq(2, b + 17, 4,  "t6_ch2");
      exp_sq(3, b + 17, 5,  "t6_ch3");
      write_cfg(1, 3, 1'b0);
      write_cfg(2, 4, 1'b0);
      goto_edge(b + 11);
      write_cfg(3, 5, 1'b0);
      goto_edge(b + 15);
      sync = 1'b1;
      write_cfg(1, 6, 1'b0);
      sync = 1'b0;
      goto_edge(b + 27);

      // Write on the wrap edge with an older write pending, then reset with pending config
      do_reset(b);
      push_exp(b + 1,  2, 0, 1'b1, "t7_pend_set");
      push_exp(b + 10, 2, 0, 1'b1, "t7_pend_wrap_wr");
      push_exp(b + 14, 2, 0, 1'b0, "t7_pend_clr");
      exp_sq(0, b + 1,  10, "t7_old");
      exp_sq(0, b + 11, 4,  "t7_first");
      for (int j = 0; j < 3; j++) begin
         push_exp(b + 15 + j, 0, 0, 1'b1, "t7_second_clk");
         push_exp(b + 15 + j, 1, 0, 1'b0, "t7_second_tick");
      end
      push_exp(b + 16, 2, 1, 1'b1, "t7_pend1_set");
      push_exp(b + 17, 2, 1, 1'b1, "t7_pend1_hold");
      write_cfg(0, 4, 1'b0);
      goto_edge(b + 9);
      write_cfg(0, 6, 1'b0);
      goto_edge(b + 15);
      write_cfg(1, 3, 1'b0);
      goto_edge(b + 17);
      do_reset(b2);
      exp_sq(0, b2 + 1, 10, "t7_rst_ch0");
      exp_sq(1, b2 + 1, 10, "t7_rst_ch1");
      goto_edge(b2 + 10);

      step(2);
      if (sbq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL leftover_expectations: got %0d unchecked, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at edge %0d, expected completion", edges);
      $fatal(1, "timeout");
   end

endmodule
